password_entry_ctrl: RTL and testbench

Sequential front end for the password lock. It collects keypad digit strobes into a 6-digit entry buffer and keeps a 3-bit entered-digit count, which drives the LED thermometer display. It compares the entry against a stored password on submit and reports open/fail status. It also supports reprogramming the stored password and an optional failed-attempt lockout.

---
 rtl/password_entry_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_password_entry_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/password_entry_ctrl.sv
// password_entry_ctrl: keypad front end for the password lock.
// Buffers up to PW_LEN digits, compares against the stored password on submit,
// holds an unlocked window, and allows reprogramming from the unlocked window.
// Optional failed-attempt lockout is built when PASSWORD_LOCKOUT_EN is defined.
//
// state   | meaning
// ENTRY   | normal digit entry
// CHECK   | one-cycle compare of the full entry against the stored password
// OPEN    | unlocked window, open timer counting down
// PROGRAM | entry of a new password
// LOCK    | failed-attempt lockout (PASSWORD_LOCKOUT_EN only)
module password_entry_ctrl #(
    parameter int                  PW_LEN      = 6,
    parameter logic [4*PW_LEN-1:0] DEFAULT_PW  = 24'h123456,
    parameter int                  OPEN_CYCLES = 16
`ifdef PASSWORD_LOCKOUT_EN
    ,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCK_CYCLES = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       backspace,
    input  logic       clear,
    input  logic       submit,
    input  logic       prog_req,
    output logic [2:0] count,
    output logic       unlocked,
    output logic       fail,
    output logic       prog_mode,
    output logic       locked
);

    localparam logic [2:0] LEN3      = 3'(PW_LEN);
    localparam int         OT_W      = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [OT_W-1:0] OPEN_LOAD = OT_W'(OPEN_CYCLES - 1);
`ifdef PASSWORD_LOCKOUT_EN
    localparam int         LT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LT_W-1:0] LOCK_LOAD = LT_W'(LOCK_CYCLES - 1);
    localparam logic [1:0] FAIL_LAST = 2'(MAX_FAIL - 1);
`endif

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        PROGRAM = 3'd3,
        LOCK    = 3'd4
    } state_t;

    state_t              state;
    logic [4*PW_LEN-1:0] entry_buf;
    logic [4*PW_LEN-1:0] stored_pw;
    logic [OT_W-1:0]     open_timer;
    logic [4*PW_LEN-1:0] edit_buf;
    logic [2:0]          edit_count;
`ifdef PASSWORD_LOCKOUT_EN
    logic [LT_W-1:0]     lock_timer;
    logic [1:0]          fail_cnt;
`endif

    // Buffer edit shared by ENTRY and PROGRAM: clear > backspace > digit; submit is
    // resolved in the FSM and takes precedence over this result when clear is low.
    always_comb begin
        edit_buf   = entry_buf;
        edit_count = count;
        if (clear) begin
            edit_buf   = '0;
            edit_count = 3'd0;
        end else if (backspace) begin
            if (count != 3'd0) begin
                edit_count = count - 3'd1;
            end
            for (int i = 0; i < PW_LEN; i++) begin
                if (count == 3'(i + 1)) begin
                    edit_buf[4*(PW_LEN-1-i) +: 4] = 4'd0;
                end
            end
        end else if (digit_valid && (digit <= 4'd9) && (count < LEN3)) begin
            edit_count = count + 3'd1;
            for (int i = 0; i < PW_LEN; i++) begin
                if (count == 3'(i)) begin
                    edit_buf[4*(PW_LEN-1-i) +: 4] = digit;
                end
            end
        end
    end

    // Main controller: state, buffer, stored password, timers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ENTRY;
            entry_buf  <= '0;
            stored_pw  <= DEFAULT_PW;
            count      <= 3'd0;
            open_timer <= '0;
            unlocked   <= 1'b0;
            fail       <= 1'b0;
            prog_mode  <= 1'b0;
`ifdef PASSWORD_LOCKOUT_EN
            lock_timer <= '0;
            fail_cnt   <= 2'd0;
            locked     <= 1'b0;
`endif
        end else begin
            fail <= 1'b0;
            case (state)
                ENTRY: begin
                    if (submit && !clear) begin
                        if (count == LEN3) begin
                            state <= CHECK;
                        end else begin
                            // Short entry fails straight away without a compare.
                            count     <= 3'd0;
                            entry_buf <= '0;
                            fail      <= 1'b1;
`ifdef PASSWORD_LOCKOUT_EN
                            fail_cnt  <= fail_cnt + 2'd1;
                            if (fail_cnt == FAIL_LAST) begin
                                state      <= LOCK;
                                locked     <= 1'b1;
                                lock_timer <= LOCK_LOAD;
                            end
`endif
                        end
                    end else begin
                        entry_buf <= edit_buf;
                        count     <= edit_count;
                    end
                end

                CHECK: begin
                    count     <= 3'd0;
                    entry_buf <= '0;
                    if (entry_buf == stored_pw) begin
                        state      <= OPEN;
                        unlocked   <= 1'b1;
                        open_timer <= OPEN_LOAD;
`ifdef PASSWORD_LOCKOUT_EN
                        fail_cnt   <= 2'd0;
`endif
                    end else begin
                        state <= ENTRY;
                        fail  <= 1'b1;
`ifdef PASSWORD_LOCKOUT_EN
                        fail_cnt <= fail_cnt + 2'd1;
                        if (fail_cnt == FAIL_LAST) begin
                            state      <= LOCK;
                            locked     <= 1'b1;
                            lock_timer <= LOCK_LOAD;
                        end
`endif
                    end
                end

                OPEN: begin
                    if (clear) begin
                        state    <= ENTRY;
                        unlocked <= 1'b0;
                    end else if (prog_req) begin
                        state     <= PROGRAM;
                        unlocked  <= 1'b0;
                        prog_mode <= 1'b1;
                        count     <= 3'd0;
                        entry_buf <= '0;
                    end else if (open_timer == '0) begin
                        state    <= ENTRY;
                        unlocked <= 1'b0;
                    end else begin
                        open_timer <= open_timer - 1'b1;
                    end
                end

                PROGRAM: begin
                    if (submit && !clear) begin
                        // A short entry is discarded; the old password stays.
                        if (count == LEN3) begin
                            stored_pw <= entry_buf;
                        end
                        state     <= ENTRY;
                        prog_mode <= 1'b0;
                        count     <= 3'd0;
                        entry_buf <= '0;
                    end else begin
                        entry_buf <= edit_buf;
                        count     <= edit_count;
                    end
                end

`ifdef PASSWORD_LOCKOUT_EN
                LOCK: begin
                    if (lock_timer == '0) begin
                        state    <= ENTRY;
                        locked   <= 1'b0;
                        fail_cnt <= 2'd0;
                    end else begin
                        lock_timer <= lock_timer - 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

`ifndef PASSWORD_LOCKOUT_EN
    // No lockout hardware in this build.
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_password_entry_ctrl.sv
// Testbench for password_entry_ctrl: directed steps from the test plan followed by
// randomized traffic, every cycle checked against a queue-based behavioural model.
module tb_password_entry_ctrl;

    localparam int PW_LEN      = 6;
    localparam int OPEN_CYCLES = 16;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 64;
`ifdef PASSWORD_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       backspace;
    logic       clear;
    logic       submit;
    logic       prog_req;
    logic [2:0] count;
    logic       unlocked;
    logic       fail;
    logic       prog_mode;
    logic       locked;

    password_entry_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .digit_valid(digit_valid),
        .digit      (digit),
        .backspace  (backspace),
        .clear      (clear),
        .submit     (submit),
        .prog_req   (prog_req),
        .count      (count),
        .unlocked   (unlocked),
        .fail       (fail),
        .prog_mode  (prog_mode),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: entered digits as a queue, stored password as an array,
    // and "cycles remaining" counters for the unlocked and lockout windows.
    int q[$];
    int pw[PW_LEN];
    bit checking;
    bit prog;
    bit exp_fail;
    int open_left;
    int lock_left;
    int fails;

    function automatic bit entry_matches();
        for (int i = 0; i < PW_LEN; i++) begin
            if (q[i] != pw[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_failure();
        exp_fail = 1'b1;
        fails++;
        if (LOCKOUT && fails == MAX_FAIL) lock_left = LOCK_CYCLES;
    endtask

    task automatic model_step(input bit rst, input bit dv, input logic [3:0] d,
                              input bit bs, input bit clr, input bit sub, input bit prq);
        exp_fail = 1'b0;
        if (rst) begin
            q.delete();
            pw = '{1, 2, 3, 4, 5, 6};
            checking = 1'b0; prog = 1'b0;
            open_left = 0; lock_left = 0; fails = 0;
            return;
        end
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
            return;
        end
        if (checking) begin
            checking = 1'b0;
            if (entry_matches()) begin
                open_left = OPEN_CYCLES;
                fails = 0;
            end else begin
                model_failure();
            end
            q.delete();
            return;
        end
        if (open_left > 0) begin
            if (clr) open_left = 0;
            else if (prq) begin
                open_left = 0;
                prog = 1'b1;
            end else open_left--;
            return;
        end
        if (clr) begin
            q.delete();
        end else if (sub) begin
            if (prog) begin
                if (q.size() == PW_LEN) begin
                    for (int i = 0; i < PW_LEN; i++) pw[i] = q[i];
                end
                q.delete();
                prog = 1'b0;
            end else if (q.size() == PW_LEN) begin
                checking = 1'b1;
            end else begin
                q.delete();
                model_failure();
            end
        end else if (bs) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (dv && d <= 4'd9 && q.size() < PW_LEN) begin
            q.push_back(int'(d));
        end
    endtask

    task automatic check_all();
        n_cmp++;
        assert (count === 3'(q.size())) else begin
            n_mis++;
            $error("FAIL count: observed %0d expected %0d", count, q.size());
        end
        n_cmp++;
        assert (unlocked === (open_left > 0)) else begin
            n_mis++;
            $error("FAIL unlocked: observed %b expected %b", unlocked, open_left > 0);
        end
        n_cmp++;
        assert (fail === exp_fail) else begin
            n_mis++;
            $error("FAIL fail: observed %b expected %b", fail, exp_fail);
        end
        n_cmp++;
        assert (prog_mode === prog) else begin
            n_mis++;
            $error("FAIL prog_mode: observed %b expected %b", prog_mode, prog);
        end
        n_cmp++;
        assert (locked === (lock_left > 0)) else begin
            n_mis++;
            $error("FAIL locked: observed %b expected %b", locked, lock_left > 0);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample just after the edge.
    task automatic cyc(input bit rst, input bit dv, input logic [3:0] d,
                       input bit bs, input bit clr, input bit sub, input bit prq);
        reset = rst; digit_valid = dv; digit = d; backspace = bs;
        clear = clr; submit = sub; prog_req = prq;
        model_step(rst, dv, d, bs, clr, sub, prq);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic press(input logic [3:0] d);
        cyc(0, 1, d, 0, 0, 0, 0);
    endtask

    task automatic enter_value(input logic [23:0] v);
        for (int i = 0; i < PW_LEN; i++) press(v[23-4*i -: 4]);
    endtask

    task automatic do_submit();
        cyc(0, 0, 4'd0, 0, 0, 1, 0);
    endtask

    task automatic do_prog_req();
        cyc(0, 0, 4'd0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset and basic entry / backspace / clear.
        cyc(1, 0, 4'd0, 0, 0, 0, 0);
        cyc(1, 1, 4'd5, 0, 0, 1, 1);
        press(4'd1); press(4'd2); press(4'd3);
        cyc(0, 0, 4'd0, 1, 0, 0, 0);
        cyc(0, 0, 4'd0, 0, 1, 0, 0);

        // Saturation at six digits, then a correct submit and the full open window.
        enter_value(24'h123456);
        press(4'd9);
        do_submit();
        idle(20);

        // Wrong full entry, then a short submit.
        enter_value(24'h123457);
        do_submit();
        idle(3);
        press(4'd1); press(4'd2); press(4'd3);
        do_submit();
        idle(2);

        // Reprogram to 987654, old password fails, new one unlocks.
        enter_value(24'h123456);
        do_submit();
        idle(2);
        do_prog_req();
        enter_value(24'h987654);
        do_submit();
        idle(2);
        enter_value(24'h123456);
        do_submit();
        idle(2);
        enter_value(24'h987654);
        do_submit();
        idle(18);

        // Reset in the middle of PROGRAM restores the default password.
        enter_value(24'h987654);
        do_submit();
        idle(1);
        do_prog_req();
        press(4'd1); press(4'd2);
        cyc(1, 0, 4'd0, 0, 0, 0, 0);
        enter_value(24'h123456);
        do_submit();
        cyc(0, 0, 4'd0, 0, 1, 0, 0);
        idle(2);

        // Same-cycle priority cases and an invalid digit.
        press(4'd5); press(4'd5);
        cyc(0, 1, 4'd7, 1, 0, 0, 0);
        cyc(0, 0, 4'd0, 0, 1, 1, 0);
        press(4'd4);
        press(4'hA);
        press(4'hF);
        cyc(0, 0, 4'd0, 0, 0, 0, 1);
        cyc(0, 0, 4'd0, 0, 1, 0, 0);

        // Five consecutive failures: lockout with digits ignored, or no lock at all.
        for (int i = 0; i < 5; i++) begin
            do_submit();
            press(4'd1);
            press(4'd2);
        end
        idle(LOCK_CYCLES + 4);
        enter_value(24'h123456);
        do_submit();
        idle(OPEN_CYCLES + 3);

        // Randomized traffic, interleaved with entries of the current password.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                cyc(0, 0, 4'd0, 0, 1, 0, 0);
                for (int i = 0; i < PW_LEN; i++) press(4'(pw[i]));
                do_submit();
                idle(1);
            end
            for (int k = 0; k < 50; k++) begin
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 99) < 45,
                    4'($urandom_range(0, 11)),
                    $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 20);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
